ov7670_axis_capture_fifo: RTL and testbench
===========================================

// Module: ov7670_axis_capture_fifo
// PURPOSE
//  Parametrised successor of the OV7670 capture-to-AXIS path: assembles 8-bit camera bytes into pixels,
//  buffers them in an internal FIFO and presents AXI4-Stream to the AXI DMA S2MM. Unlike the prior path,
//  it honours m_axis_tready, detects overflow and drops the rest of a corrupted frame,
//  and generates tlast on the true last pixel of each line.
// PARAMETERS
//  DATA_WIDTH  16  pixel width on m_axis_tdata; only 16 is legal (two camera bytes per pixel)
//  FIFO_DEPTH  16  FIFO entries, power of 2, >=4; entry = {tuser,tlast,tdata}
//  BYTE_SWAP   0   0: first byte of pair -> tdata[15:8]; 1: first byte -> tdata[7:0]
//  CNT_WIDTH   16  width of frame_count and drop_count
// PORTS
//  pclk            in   1          camera pixel clock; the only clock in the block
//  rst_n           in   1          asynchronous, active-low reset
//  enable_capture  in   1          frame gating, sampled only at vsync falling edge
//  vsync           in   1          camera vsync, high = vertical blanking
//  href            in   1          camera href, high = valid byte on d
//  d               in   8          camera data byte
//  status_clear    in   1          1-cycle pulse: clears overflow
//  m_axis_tdata    out  DATA_WIDTH pixel
//  m_axis_tvalid   out  1          FIFO not empty
//  m_axis_tready   in   1          sink ready
//  m_axis_tuser    out  1          start of frame (first pixel of frame)
//  m_axis_tlast    out  1          last pixel of line
//  overflow        out  1          sticky: a pixel write hit a full FIFO
//  frame_count     out  CNT_WIDTH  frames started (sof written), wraps
//  drop_count      out  CNT_WIDTH  frames truncated by overflow, saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, byte phase 0, no pending pixel, counters 0.
//  vsync edges are detected from a 1-cycle registered copy of vsync (inputs are already in pclk domain).
//  FSM: IDLE -> (vsync fall & enable_capture) ACTIVE; IDLE -> (vsync fall & !enable_capture) SKIP;
//   ACTIVE -> (write while full) DROP; ACTIVE/DROP/SKIP -> (vsync rise) IDLE.
//   enable_capture deasserting mid-frame has no effect until next vsync fall.
//  Byte assembly (ACTIVE only): byte phase toggles on each href=1 cycle, forced to 0 when href=0;
//   phase-1 byte completes a pixel. Odd trailing byte at href fall is discarded.
//  Pending register: a completed pixel is held one pixel; it is written to FIFO with tlast=0 when the next
//   pixel completes, or with tlast=1 on the first cycle href=0 after the line (or at vsync rise if href
//   still high). tuser=1 on the first pixel written after entering ACTIVE.
//  Latency: pixel visible on m_axis_tvalid 1 cycle after its FIFO write (first-word fall-through).
//  AXIS: transfer when tvalid&tready; tdata/tuser/tlast stable while tvalid&!tready; tvalid never
//   depends combinationally on tready.
//  Full FIFO: a write coinciding with a pop is accepted. Write while full with no pop -> entry dropped,
//   overflow<=1, drop_count+1 (saturating), FSM -> DROP; pending pixel discarded;
//   no further writes until next frame. Entries already in FIFO drain normally.
//  overflow: set has priority over status_clear in the same cycle.
//  frame_count increments on the cycle the tuser=1 entry is written.
//  Reset mid-frame: immediate return to reset state, FIFO contents lost.
// TESTING
//  1. 4-line x 4-pixel frame, tready=1, bytes 0x12,0x34.. -> tdata 0x1234.., tuser on pixel 0 only,
//     tlast on pixels 3,7,11,15, frame_count=1.
//  2. BYTE_SWAP=1, bytes 0xAB,0xCD -> tdata 0xCDAB.
//  3. enable_capture=0 at vsync fall, 1 mid-frame -> no output for that frame, frame_count unchanged.
//  4. FIFO_DEPTH=4, tready=0 for 64-pixel line -> 4 entries held stable, overflow=1, drop_count=1,
//     after tready=1 exactly 4 beats, next frame captured intact with tuser.
//  5. Odd byte count (9 bytes) per line -> 4 pixels, tlast on pixel 3, stray byte discarded.
//  6. rst_n low mid-line with tvalid=1 -> tvalid=0 asynchronously, counters 0; status_clear with
//     simultaneous new overflow -> overflow stays 1.

Source files
------------

// File: rtl/ov7670_axis_capture_fifo.sv
// Purpose: OV7670 byte stream -> 16-bit pixels -> FWFT FIFO -> AXI4-Stream master (tuser=SOF, tlast=EOL).
// Latency: pixel held one pixel in a pending register, then visible on m_axis_tvalid 1 cycle after its FIFO write.
// Backpressure: honours m_axis_tready; a write into a full FIFO drops the rest of the frame and flags overflow.

// Purpose: generic first-word-fall-through FIFO, power-of-2 depth.
// Latency: written word is visible on rd_vld/rd_dat on the cycle after the write.
// Backpressure: wr_rdy low only when full with no pop in the same cycle; rd_dat forced to 0 while empty.
module fifo_fwft #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;

    assign rd_vld = (count != '0);
    assign pop    = rd_vld & rd_rdy;
    // A pop frees the slot the write lands in, so full+pop still accepts.
    assign wr_rdy = (count != FULL_CNT) | pop;
    assign push   = wr_vld & wr_rdy;
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ov7670_axis_capture_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int BYTE_SWAP  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  enable_capture,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            d,
    input  logic                  status_clear,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP, SKIP} state_t;
    state_t state, state_nxt;

    logic                  vsync_q, phase, pend_vld, pend_user, sof_flag;
    logic [7:0]            byte_hi;
    logic [DATA_WIDTH-1:0] pend_dat, pixel;
    logic                  vs_fall, vs_rise, pix_done;
    logic                  wr_req, wr_tlast, wr_rdy, wr_ok, wr_drop;
    logic [EW-1:0]         fifo_wr_dat, fifo_rd_dat;

    assign vs_fall  = vsync_q & ~vsync;
    assign vs_rise  = ~vsync_q & vsync;
    assign pix_done = (state == ACTIVE) & href & phase & ~vs_rise;
    assign pixel    = (BYTE_SWAP != 0) ? {d, byte_hi} : {byte_hi, d};

    // Pending pixel leaves as a mid-line beat when its successor completes,
    // otherwise as end-of-line (href dropped, or frame ended with href high).
    assign wr_req      = (state == ACTIVE) & pend_vld & (pix_done | ~href | vs_rise);
    assign wr_tlast    = ~pix_done;
    assign wr_ok       = wr_req & wr_rdy;
    assign wr_drop     = wr_req & ~wr_rdy;
    assign fifo_wr_dat = {pend_user, wr_tlast, pend_dat};

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (vs_fall) state_nxt = enable_capture ? ACTIVE : SKIP;
            ACTIVE: if (vs_rise) state_nxt = IDLE;
                    else if (wr_drop) state_nxt = DROP;
            DROP:   if (vs_rise) state_nxt = IDLE;
            SKIP:   if (vs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            phase       <= 1'b0;
            byte_hi     <= '0;
            pend_vld    <= 1'b0;
            pend_dat    <= '0;
            pend_user   <= 1'b0;
            sof_flag    <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            vsync_q <= vsync;

            if (state == IDLE && vs_fall && enable_capture) sof_flag <= 1'b1;
            else if (pix_done)                              sof_flag <= 1'b0;

            if (state == ACTIVE && !vs_rise && !wr_drop) begin
                phase <= href ? ~phase : 1'b0;
                if (href && !phase) byte_hi <= d;
                if (pix_done) begin
                    pend_vld  <= 1'b1;
                    pend_dat  <= pixel;
                    pend_user <= sof_flag;
                end else if (wr_ok) begin
                    pend_vld <= 1'b0;
                end
            end else begin
                // Outside ACTIVE (or on the cycle of leaving it) nothing is carried over.
                phase    <= 1'b0;
                pend_vld <= 1'b0;
            end

            if (wr_drop)           overflow <= 1'b1;
            else if (status_clear) overflow <= 1'b0;

            if (wr_drop && drop_count != '1) drop_count  <= drop_count + 1'b1;
            if (wr_ok && pend_user)          frame_count <= frame_count + 1'b1;
        end
    end

    fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (pclk),
        .rst_n  (rst_n),
        .wr_vld (wr_req),
        .wr_dat (fifo_wr_dat),
        .wr_rdy (wr_rdy),
        .rd_vld (m_axis_tvalid),
        .rd_dat (fifo_rd_dat),
        .rd_rdy (m_axis_tready)
    );

    assign m_axis_tdata = fifo_rd_dat[DATA_WIDTH-1:0];
    assign m_axis_tlast = fifo_rd_dat[DATA_WIDTH];
    assign m_axis_tuser = fifo_rd_dat[DATA_WIDTH+1];
endmodule

// File: tb/tb_ov7670_axis_capture_fifo.sv
// Two instances share the camera stream: A is default (depth 16, no swap),
// B is depth 4 with byte swap, used for backpressure/overflow cases.
module tb_ov7670_axis_capture_fifo;
    logic        pclk = 1'b0;
    logic        rst_n, enable_capture, vsync, href, status_clear;
    logic [7:0]  d;
    logic        tready_a, tready_b;
    logic [15:0] tdata_a, tdata_b, fc_a, fc_b, dc_a, dc_b;
    logic        tvalid_a, tvalid_b, tuser_a, tuser_b, tlast_a, tlast_b, ovf_a, ovf_b;

    int tests = 0;
    int errors = 0;
    int beats_b = 0;
    int b_cnt = 0;
    logic [17:0] q_a[$];
    logic [17:0] q_b[$];

    typedef struct {
        int         lines;
        int         nbytes;
        bit         en_fall;
        bit         en_mid;
        logic [7:0] seed;
        int         exp_fc;
    } frame_t;
    frame_t tbl[5];

    always #5 pclk = ~pclk;

    ov7670_axis_capture_fifo dut_a (
        .pclk(pclk), .rst_n(rst_n), .enable_capture(enable_capture), .vsync(vsync),
        .href(href), .d(d), .status_clear(status_clear),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .m_axis_tuser(tuser_a), .m_axis_tlast(tlast_a), .overflow(ovf_a),
        .frame_count(fc_a), .drop_count(dc_a)
    );

    ov7670_axis_capture_fifo #(.FIFO_DEPTH(4), .BYTE_SWAP(1)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .enable_capture(enable_capture), .vsync(vsync),
        .href(href), .d(d), .status_clear(status_clear),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .m_axis_tuser(tuser_b), .m_axis_tlast(tlast_b), .overflow(ovf_b),
        .frame_count(fc_b), .drop_count(dc_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [7:0] bval(input logic [7:0] seed, input int i);
        return seed + 8'(i * 34);
    endfunction

    always @(negedge pclk) begin
        if (rst_n && tvalid_a && tready_a) begin
            if (q_a.size() == 0) begin
                tests++; errors++;
                $display("FAIL A unexpected beat: got %h expected none", {tuser_a, tlast_a, tdata_a});
            end else begin
                check("A beat", {tuser_a, tlast_a, tdata_a}, q_a.pop_front());
            end
        end
        if (rst_n && tvalid_b && tready_b) begin
            beats_b++;
            if (q_b.size() == 0) begin
                tests++; errors++;
                $display("FAIL B unexpected beat: got %h expected none", {tuser_b, tlast_b, tdata_b});
            end else begin
                check("B beat", {tuser_b, tlast_b, tdata_b}, q_b.pop_front());
            end
        end
    end

    task automatic send_frame(input int lines, input int nbytes, input bit en_fall, input bit en_mid,
                              input logic [7:0] seed, input int b_max, input int clr_at);
        logic       u, la;
        logic [7:0] b0, b1;
        vsync = 1'b1; enable_capture = en_fall;
        repeat (3) tick();
        vsync = 1'b0;
        tick();
        enable_capture = en_mid;
        repeat (2) tick();
        b_cnt = 0;
        for (int l = 0; l < lines; l++) begin
            if (en_fall) begin
                for (int p = 0; p < nbytes / 2; p++) begin
                    b0 = bval(seed, l * nbytes + 2 * p);
                    b1 = bval(seed, l * nbytes + 2 * p + 1);
                    u  = (l == 0 && p == 0);
                    la = (p == nbytes / 2 - 1);
                    q_a.push_back({u, la, b0, b1});
                    if (b_cnt < b_max) begin
                        q_b.push_back({u, la, b1, b0});
                        b_cnt++;
                    end
                end
            end
            for (int k = 0; k < nbytes; k++) begin
                href = 1'b1;
                d = bval(seed, l * nbytes + k);
                status_clear = (l == 0 && k == clr_at);
                tick();
            end
            href = 1'b0; d = 8'h00; status_clear = 1'b0;
            repeat (3) tick();
        end
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic wait_drain(input bit inc_b);
        int i;
        i = 0;
        while (i < 300 && (q_a.size() != 0 || (inc_b && q_b.size() != 0))) begin
            tick();
            i++;
        end
        check("drain A", q_a.size(), 0);
        if (inc_b) check("drain B", q_b.size(), 0);
    endtask

    initial begin
        tbl[0] = '{4, 8, 1'b1, 1'b1, 8'h12, 1};
        tbl[1] = '{2, 9, 1'b1, 1'b1, 8'hAB, 2};
        tbl[2] = '{2, 8, 1'b0, 1'b1, 8'h50, 2};
        tbl[3] = '{1, 2, 1'b1, 1'b0, 8'h77, 3};
        tbl[4] = '{3, 4, 1'b1, 1'b1, 8'h03, 4};

        rst_n = 1'b0; enable_capture = 1'b0; vsync = 1'b1; href = 1'b0; d = 8'h00;
        status_clear = 1'b0; tready_a = 1'b1; tready_b = 1'b1;
        repeat (3) tick();
        check("reset A outputs", {tvalid_a, tuser_a, tlast_a, ovf_a, tdata_a}, 0);
        check("reset A counters", {fc_a, dc_a}, 0);
        check("reset B outputs", {tvalid_b, tuser_b, tlast_b, ovf_b, tdata_b}, 0);
        check("reset B counters", {fc_b, dc_b}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int f = 0; f < 5; f++) begin
            send_frame(tbl[f].lines, tbl[f].nbytes, tbl[f].en_fall, tbl[f].en_mid, tbl[f].seed, 1000, -1);
            wait_drain(1'b1);
            check($sformatf("frame %0d fc A", f), fc_a, tbl[f].exp_fc);
            check($sformatf("frame %0d fc B", f), fc_b, tbl[f].exp_fc);
            check($sformatf("frame %0d no ovf", f), {ovf_a, ovf_b, dc_a, dc_b}, 0);
        end

        // Overflow on B: 64-pixel line with no sink, clear pulse lands on the dropping write.
        tready_b = 1'b0;
        send_frame(1, 128, 1'b1, 1'b1, 8'h21, 4, 11);
        wait_drain(1'b0);
        check("ovf B set despite clear", ovf_b, 1);
        check("drop_count B", dc_b, 1);
        check("no ovf A", {ovf_a, dc_a}, 0);
        check("fc A after long line", fc_a, 5);
        check("fc B after overflow frame", fc_b, 5);
        for (int i = 0; i < 8; i++) begin
            check("B held beat", {tvalid_b, tuser_b, tlast_b, tdata_b}, {1'b1, q_b[0]});
            tick();
        end
        beats_b = 0;
        tready_b = 1'b1;
        wait_drain(1'b1);
        repeat (4) tick();
        check("B beats after release", beats_b, 4);
        check("B empty after release", tvalid_b, 0);
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        check("ovf B cleared", ovf_b, 0);

        send_frame(2, 8, 1'b1, 1'b1, 8'h90, 1000, -1);
        wait_drain(1'b1);
        check("fc B recovered", fc_b, 6);
        check("drop_count B held", dc_b, 1);

        // Asynchronous reset mid-line with data waiting in both FIFOs.
        tready_a = 1'b0; tready_b = 1'b0;
        vsync = 1'b1; enable_capture = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 9; k++) begin
            href = 1'b1; d = 8'(k + 1);
            tick();
        end
        @(posedge pclk);
        #3;
        check("tvalid A before reset", tvalid_a, 1);
        rst_n = 1'b0;
        #1;
        check("tvalid async reset", {tvalid_a, tvalid_b}, 0);
        check("counters async reset", {fc_a, fc_b, dc_a, dc_b}, 0);
        href = 1'b0; vsync = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tready_a = 1'b1; tready_b = 1'b1;
        tick();
        send_frame(1, 4, 1'b1, 1'b1, 8'h40, 1000, -1);
        wait_drain(1'b1);
        check("fc after reset frame", {fc_a, fc_b}, {16'd1, 16'd1});

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
